// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped write-back L1 data cache.
// Tags are stored wide enough for the smallest legal cache (two lines).
package dcache_ctrl_pkg;

  localparam int XLEN            = 32;
  localparam int ADDR_LEN        = 32;
  localparam int NUM_CACHE_LINES = 4;
  localparam int LINE_BYTES      = 16;
  localparam int LINE_W          = LINE_BYTES * 8;
  localparam int OFFSET_W        = $clog2(LINE_BYTES);
  localparam int INDEX_W         = $clog2(NUM_CACHE_LINES);
  localparam int TAG_W           = ADDR_LEN - OFFSET_W - 1;

  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } data_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    UPDATE
  } dcache_state_e;

  typedef enum logic [1:0] {
    WR_BYTE,
    WR_WORD,
    WR_LINE
  } dcache_wr_mode_e;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } dcache_line_t;

  typedef struct packed {
    logic                req;
    logic                we;
    logic [ADDR_LEN-1:0] addr;
    logic [LINE_W-1:0]   wdata;
  } mem_req_t;

  function automatic logic [LINE_W-1:0] mergeStore(input logic [LINE_W-1:0]   line,
                                                   input logic [OFFSET_W-1:0] offset,
                                                   input logic [XLEN-1:0]     data,
                                                   input data_size_e          size);
    logic [LINE_W-1:0] merged;
    merged = line;
    if (size == WORD) merged[{offset[OFFSET_W-1:2], 5'b0} +: XLEN] = data;
    else              merged[{offset, 3'b0} +: 8]                  = data[7:0];
    return merged;
  endfunction

  // WORD ignores the byte lane; BYTE is zero-extended.
  function automatic logic [XLEN-1:0] loadExtract(input logic [LINE_W-1:0]   line,
                                                  input logic [OFFSET_W-1:0] offset,
                                                  input data_size_e          size);
    logic [XLEN-1:0] result;
    if (size == WORD) result = line[{offset[OFFSET_W-1:2], 5'b0} +: XLEN];
    else              result = {{(XLEN-8){1'b0}}, line[{offset, 3'b0} +: 8]};
    return result;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Pipeline load, store-buffer drain and line memory port of the data cache.
interface dcache_ctrl_if;
  import dcache_ctrl_pkg::*;

  logic                load_req_in;
  logic [ADDR_LEN-1:0] load_addr_in;
  data_size_e          load_size_in;
  logic [XLEN-1:0]     load_data_out;
  logic                load_valid_out;
  logic                stb_flush_in;
  logic [ADDR_LEN-1:0] stb_addr_in;
  logic [XLEN-1:0]     stb_data_in;
  data_size_e          stb_size_in;
  logic                stall_out;
  logic                mem_req_out;
  logic                mem_we_out;
  logic [ADDR_LEN-1:0] mem_addr_out;
  logic [LINE_W-1:0]   mem_wdata_out;
  logic                mem_ready_in;
  logic [LINE_W-1:0]   mem_rdata_in;

  modport slave (
    input  load_req_in, load_addr_in, load_size_in,
    input  stb_flush_in, stb_addr_in, stb_data_in, stb_size_in,
    input  mem_ready_in, mem_rdata_in,
    output load_data_out, load_valid_out, stall_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out
  );

  modport master (
    output load_req_in, load_addr_in, load_size_in,
    output stb_flush_in, stb_addr_in, stb_data_in, stb_size_in,
    output mem_ready_in, mem_rdata_in,
    input  load_data_out, load_valid_out, stall_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out
  );

endinterface

// File: rtl/dcache_ctrl_array.sv
// Valid/dirty/tag/data storage: one combinational read port, one write port
// that either patches a byte/word of a resident line or installs a full line.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = NUM_CACHE_LINES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_LINES)-1:0] rd_index_i,
  output dcache_line_t                 rd_line_o,
  input  logic                         we_i,
  input  dcache_wr_mode_e              mode_i,
  input  logic [$clog2(NUM_LINES)-1:0] wr_index_i,
  input  logic [OFFSET_W-1:0]          wr_offset_i,
  input  logic [XLEN-1:0]              wr_word_i,
  input  logic [LINE_W-1:0]            wr_line_i,
  input  logic [TAG_W-1:0]             wr_tag_i,
  input  logic                         wr_dirty_i
);

  logic              valid_q [NUM_LINES];
  logic              dirty_q [NUM_LINES];
  logic [TAG_W-1:0]  tag_q   [NUM_LINES];
  logic [LINE_W-1:0] data_q  [NUM_LINES];

  always_comb begin
    rd_line_o.valid = valid_q[rd_index_i];
    rd_line_o.dirty = dirty_q[rd_index_i];
    rd_line_o.tag   = tag_q[rd_index_i];
    rd_line_o.data  = data_q[rd_index_i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
      end
    end else if (we_i) begin
      if (mode_i == WR_LINE) begin
        valid_q[wr_index_i] <= 1'b1;
        dirty_q[wr_index_i] <= wr_dirty_i;
      end else begin
        dirty_q[wr_index_i] <= 1'b1;
      end
    end
  end

  // Tag and data payload carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      if (mode_i == WR_LINE) begin
        tag_q[wr_index_i]  <= wr_tag_i;
        data_q[wr_index_i] <= wr_line_i;
      end else begin
        data_q[wr_index_i] <= mergeStore(data_q[wr_index_i], wr_offset_i, wr_word_i,
                                         (mode_i == WR_WORD) ? WORD : BYTE);
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller: hit path,
// store-buffer drain and the miss FSM driving the line-granular memory port.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = NUM_CACHE_LINES
) (
  input logic          clk,
  input logic          reset,
  dcache_ctrl_if.slave bus
);

  localparam int IW = $clog2(NUM_LINES);

  dcache_state_e       state_q, state_d;
  logic                memReq_q, memReq_d;
  logic                memWe_q, memWe_d;
  logic                pendStore_q, pendStore_d;
  logic [ADDR_LEN-1:0] pendAddr_q, pendAddr_d;
  logic [XLEN-1:0]     pendData_q, pendData_d;
  data_size_e          pendSize_q, pendSize_d;
  logic [LINE_W-1:0]   refill_q, refill_d;

  logic [ADDR_LEN-1:0] lookupAddr;
  logic [IW-1:0]       lookupIndex;
  logic [OFFSET_W-1:0] lookupOffset;
  logic [TAG_W-1:0]    lookupTag;
  dcache_line_t        rdLine;
  logic                hit, victimDirty;
  logic                stallC, loadValidC, loadValid;
  logic                arrWe;
  dcache_wr_mode_e     arrMode;
  logic [LINE_W-1:0]   arrLine;
  mem_req_t            memOut;

  // Flush owns the single lookup port in IDLE; during a miss it follows the pending request.
  always_comb begin
    if (state_q == IDLE) lookupAddr = bus.stb_flush_in ? bus.stb_addr_in : bus.load_addr_in;
    else                 lookupAddr = pendAddr_q;
  end

  assign lookupOffset = lookupAddr[OFFSET_W-1:0];
  assign lookupIndex  = lookupAddr[OFFSET_W+IW-1:OFFSET_W];
  assign lookupTag    = TAG_W'(lookupAddr[ADDR_LEN-1:OFFSET_W+IW]);
  assign hit          = rdLine.valid && (rdLine.tag == lookupTag);
  assign victimDirty  = rdLine.valid && rdLine.dirty;
  assign arrLine      = pendStore_q ? mergeStore(refill_q, pendAddr_q[OFFSET_W-1:0], pendData_q, pendSize_q)
                                    : refill_q;

  dcache_array #(.NUM_LINES(NUM_LINES)) u_array (
    .clk         (clk),
    .reset       (reset),
    .rd_index_i  (lookupIndex),
    .rd_line_o   (rdLine),
    .we_i        (arrWe),
    .mode_i      (arrMode),
    .wr_index_i  (lookupIndex),
    .wr_offset_i (lookupOffset),
    .wr_word_i   (bus.stb_data_in),
    .wr_line_i   (arrLine),
    .wr_tag_i    (lookupTag),
    .wr_dirty_i  (pendStore_q)
  );

  always_comb begin
    state_d     = state_q;
    memReq_d    = memReq_q;
    memWe_d     = memWe_q;
    pendStore_d = pendStore_q;
    pendAddr_d  = pendAddr_q;
    pendData_d  = pendData_q;
    pendSize_d  = pendSize_q;
    refill_d    = refill_q;
    stallC      = 1'b0;
    loadValidC  = 1'b0;
    arrWe       = 1'b0;
    arrMode     = WR_LINE;

    unique case (state_q)
      IDLE: begin
        if (bus.stb_flush_in && hit) begin
          arrWe   = 1'b1;
          arrMode = (bus.stb_size_in == WORD) ? WR_WORD : WR_BYTE;
          stallC  = bus.load_req_in;
        end else if (bus.load_req_in && !bus.stb_flush_in && hit) begin
          loadValidC = 1'b1;
        end else if (bus.stb_flush_in || bus.load_req_in) begin
          stallC      = 1'b1;
          pendStore_d = bus.stb_flush_in;
          pendAddr_d  = lookupAddr;
          pendData_d  = bus.stb_data_in;
          pendSize_d  = bus.stb_flush_in ? bus.stb_size_in : bus.load_size_in;
          memReq_d    = 1'b1;
          memWe_d     = victimDirty;
          state_d     = victimDirty ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stallC = 1'b1;
        if (memReq_q && bus.mem_ready_in) begin
          memReq_d = 1'b0;
          memWe_d  = 1'b0;
          state_d  = REFILL;
        end
      end
      // After a writeback the request stays low for one cycle before the refill rises.
      REFILL: begin
        stallC = 1'b1;
        if (!memReq_q) begin
          memReq_d = 1'b1;
        end else if (bus.mem_ready_in) begin
          refill_d = bus.mem_rdata_in;
          memReq_d = 1'b0;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        stallC  = 1'b1;
        arrWe   = 1'b1;
        arrMode = WR_LINE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      pendStore_q <= 1'b0;
      pendAddr_q  <= '0;
      pendData_q  <= '0;
      pendSize_q  <= WORD;
      refill_q    <= '0;
    end else begin
      state_q     <= state_d;
      memReq_q    <= memReq_d;
      memWe_q     <= memWe_d;
      pendStore_q <= pendStore_d;
      pendAddr_q  <= pendAddr_d;
      pendData_q  <= pendData_d;
      pendSize_q  <= pendSize_d;
      refill_q    <= refill_d;
    end
  end

  always_comb begin
    memOut.req   = memReq_q;
    memOut.we    = memWe_q;
    memOut.wdata = rdLine.data;
    memOut.addr  = (state_q == WRITEBACK) ? ADDR_LEN'({rdLine.tag, lookupIndex, OFFSET_W'(0)})
                                          : {pendAddr_q[ADDR_LEN-1:OFFSET_W], OFFSET_W'(0)};
  end

  // Gating with reset keeps the pipeline-facing outputs quiet while reset is held.
  assign loadValid          = reset & loadValidC;
  assign bus.stall_out      = reset & stallC;
  assign bus.load_valid_out = loadValid;
  assign bus.load_data_out  = loadValid ? loadExtract(rdLine.data, lookupOffset, bus.load_size_in) : '0;
  assign bus.mem_req_out    = memOut.req;
  assign bus.mem_we_out     = memOut.we;
  assign bus.mem_addr_out   = memOut.addr;
  assign bus.mem_wdata_out  = memOut.wdata;

endmodule
